ad1868_decoder: RTL
===================

// Module: ad1868_decoder
// PURPOSE
//  Front-end stage feeding I2sEncoder: deserialises the AD1868-style DAC bus
//  (shared bit clock CK, per-channel data DL/DR, per-channel latches LL/LR)
//  from the sound source into parallel signed L/R words. Holds the last
//  complete sample pair stable for I2sEncoder's i_data_l/i_data_r and flags
//  short words and a dead bus (mute).
// PARAMETERS
//  WIDTH        16    bits per channel word; the last WIDTH bits before a latch are kept
//  SYNC_STAGES  2     flip-flop stages on every serial input (min 2)
//  TIMEOUT      4096  i_clk cycles without any latch before the bus is declared dead
//  MUTE         1     1: zero data outputs on timeout; 0: hold last data
// PORTS
//  i_clk     in   1      system clock; must be >= 4x serial CK frequency
//  i_rst     in   1      synchronous, active-high reset
//  i_ser_ck  in   1      serial bit clock, async; data valid on rising edge
//  i_ser_dl  in   1      left data, MSB first, async
//  i_ser_dr  in   1      right data, MSB first, async
//  i_ser_ll  in   1      left latch, async; word taken on falling edge
//  i_ser_lr  in   1      right latch, async; word taken on falling edge
//  o_data_l  out  WIDTH  last captured left word
//  o_data_r  out  WIDTH  last captured right word
//  o_valid   out  1      1-cycle pulse: a new L/R pair is complete
//  o_short   out  1      1-cycle pulse: a latch arrived with < WIDTH bits shifted
//  o_active  out  1      1 while the bus is alive (latch seen within TIMEOUT)
// BEHAVIOUR
//  - Reset: o_data_l=o_data_r=0, o_valid=o_short=o_active=0; shift regs, bit
//    counters, pair flags, timeout counter cleared; synchroniser FFs cleared to 0.
//  - Edges detected on last two synchroniser outputs (sync_q vs previous).
//  - CK rise: sr_l <= {sr_l[WIDTH-2:0], dl_s}; sr_r likewise with dr_s;
//    cnt_l/cnt_r increment, saturating at WIDTH.
//  - LL fall: o_data_l <= sr_l (pre-shift value if CK rises same cycle; that
//    bit enters the next word); cnt_l <= 0 (or 1 if CK rises same cycle);
//    got_l <= 1; o_short pulses if cnt_l < WIDTH. LR fall symmetric.
//  - Pair: when got_l and got_r are both set (incl. same-cycle LL/LR falls),
//    o_valid pulses next cycle and both flags clear; a second LL before any LR
//    overwrites o_data_l, no extra o_valid.
//  - Latency: pin edge -> output register update = SYNC_STAGES+1 i_clk cycles;
//    o_valid one cycle after the completing data update.
//  - Timeout: counter cleared by any latch fall, else increments (saturating).
//    At TIMEOUT: o_active <= 0, got_l/got_r cleared, data <= 0 if MUTE.
//    o_active <= 1 on the next latch fall of either channel.
//  - FSM (bus state): IDLE (after reset, !o_active) -> RUN on first latch
//    fall; RUN -> IDLE on timeout; reset from any state -> IDLE in one cycle,
//    discarding partial words (no o_valid, no o_short).
//  - Data outputs change only in the capture cycle or timeout mute, so the
//    downstream I2sEncoder may sample at its own o_latch without handshake.
// TESTING
//  - L=16'hF0F0, R=16'h0F0F shifted MSB-first, LL then LR fall -> o_data_l=F0F0,
//    o_data_r=0F0F, single o_valid, o_active=1, o_short never.
//  - 20 bits shifted (4 junk bits 4'hA then 16'h1234) -> o_data=16'h1234, no o_short.
//  - only 12 CK rises before LL fall -> o_short pulse, o_data_l = low 16 bits of sr_l.
//  - LL and LR fall same cycle with 16'h8001/16'h7FFE -> both captured, o_valid once.
//  - no latch for 4096 cycles after a valid pair -> o_active=0, data=0 (MUTE=1);
//    next latch -> o_active=1.
//  - i_rst asserted mid-word (8 bits in) -> all outputs 0 next cycle; next full
//    word decodes correctly with no o_short.

Source files
------------

// File: rtl/ad1868_decoder.sv
// ad1868_decoder: deserialises an AD1868-style serial DAC bus (CK, DL/DR, LL/LR) into
// parallel left/right words, flagging short words and a dead bus.
module ad1868_decoder #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter bit          MUTE        = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ser_ck,
    input  logic             i_ser_dl,
    input  logic             i_ser_dr,
    input  logic             i_ser_ll,
    input  logic             i_ser_lr,
    output logic [WIDTH-1:0] o_data_l,
    output logic [WIDTH-1:0] o_data_r,
    output logic             o_valid,
    output logic             o_short,
    output logic             o_active
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_FULL  = TW'(TIMEOUT);

    typedef enum logic {StIdle, StRun} state_t;

    // Bit order in each sync word: {ck, dl, dr, ll, lr}
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  prev_q;
    logic [4:0]                  pins;
    logic [4:0]                  cur;

    logic ck_rise, ll_fall, lr_fall, latch_any, dl_s, dr_s;
    logic short_l, short_r, pair, timeout_hit;

    state_t           state_q;
    logic [WIDTH-1:0] sr_l_q, sr_r_q;
    logic [CW-1:0]    cnt_l_q, cnt_r_q, cnt_l_d, cnt_r_d;
    logic             got_l_q, got_r_q;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;

    assign pins = {i_ser_ck, i_ser_dl, i_ser_dr, i_ser_ll, i_ser_lr};
    assign cur  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
            prev_q <= cur;
        end
    end

    assign ck_rise   = cur[4] & ~prev_q[4];
    assign dl_s      = cur[3];
    assign dr_s      = cur[2];
    assign ll_fall   = ~cur[1] & prev_q[1];
    assign lr_fall   = ~cur[0] & prev_q[0];
    assign latch_any = ll_fall | lr_fall;

    assign short_l     = ll_fall && (cnt_l_q < CNT_FULL);
    assign short_r     = lr_fall && (cnt_r_q < CNT_FULL);
    assign pair        = got_l_q & got_r_q;
    assign timeout_hit = !latch_any && (to_cnt_q == TO_LAST);

    // A CK rise coinciding with a latch fall belongs to the next word.
    always_comb begin
        cnt_l_d = cnt_l_q;
        cnt_r_d = cnt_r_q;
        if (ck_rise && cnt_l_q != CNT_FULL) cnt_l_d = cnt_l_q + 1'b1;
        if (ck_rise && cnt_r_q != CNT_FULL) cnt_r_d = cnt_r_q + 1'b1;
        if (ll_fall) cnt_l_d = {{(CW-1){1'b0}}, ck_rise};
        if (lr_fall) cnt_r_d = {{(CW-1){1'b0}}, ck_rise};
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (latch_any) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_FULL) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            sr_l_q   <= '0;
            sr_r_q   <= '0;
            cnt_l_q  <= '0;
            cnt_r_q  <= '0;
            got_l_q  <= 1'b0;
            got_r_q  <= 1'b0;
            to_cnt_q <= '0;
            o_data_l <= '0;
            o_data_r <= '0;
            o_valid  <= 1'b0;
            o_short  <= 1'b0;
            o_active <= 1'b0;
        end else begin
            o_valid  <= pair;
            o_short  <= short_l | short_r;
            cnt_l_q  <= cnt_l_d;
            cnt_r_q  <= cnt_r_d;
            to_cnt_q <= to_cnt_d;
            got_l_q  <= ll_fall | (got_l_q & ~pair);
            got_r_q  <= lr_fall | (got_r_q & ~pair);
            if (ck_rise) begin
                sr_l_q <= {sr_l_q[WIDTH-2:0], dl_s};
                sr_r_q <= {sr_r_q[WIDTH-2:0], dr_s};
            end
            if (ll_fall) o_data_l <= sr_l_q;
            if (lr_fall) o_data_r <= sr_r_q;

            unique case (state_q)
                StIdle: begin
                    if (latch_any) begin
                        state_q  <= StRun;
                        o_active <= 1'b1;
                    end
                end
                StRun: begin
                    if (timeout_hit) begin
                        state_q  <= StIdle;
                        o_active <= 1'b0;
                        got_l_q  <= 1'b0;
                        got_r_q  <= 1'b0;
                        if (MUTE) begin
                            o_data_l <= '0;
                            o_data_r <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
